// File: rtl/full_adder_core_pkg.sv
// Shared constants for the adder core and the PC-path logic that feeds it.
// Nothing here is width-specific beyond the defaults used by the RV32I datapath.

package full_adder_core_pkg;

    localparam int unsigned DEFAULT_WIDTH = 32;
    localparam int unsigned MIN_WIDTH     = 1;
    localparam int unsigned MAX_WIDTH     = 64;

    // Fetch address after reset in the PC path; typical A operand for branch targets.
    localparam logic [31:0] RESET_VECTOR  = 32'h8000_0000;

endpackage : full_adder_core_pkg

// File: rtl/full_adder_core_if.sv
// Operand/result bundle of the adder core. Clock and reset stay plain ports
// on the core; the producer holds the master modport and the core holds the slave.

interface full_adder_core_if
    import full_adder_core_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
);

    logic [WIDTH-1:0] A_i;
    logic [WIDTH-1:0] B_i;
    logic             Cin;
    logic             in_valid;

    logic [WIDTH-1:0] Sum;
    logic             Cout;

    logic [WIDTH-1:0] Sum_q;
    logic             Cout_q;
    logic             Ovf_q;
    logic             Zero_q;
    logic             out_valid;

    modport master (
        output A_i,
        output B_i,
        output Cin,
        output in_valid,
        input  Sum,
        input  Cout,
        input  Sum_q,
        input  Cout_q,
        input  Ovf_q,
        input  Zero_q,
        input  out_valid
    );

    modport slave (
        input  A_i,
        input  B_i,
        input  Cin,
        input  in_valid,
        output Sum,
        output Cout,
        output Sum_q,
        output Cout_q,
        output Ovf_q,
        output Zero_q,
        output out_valid
    );

endinterface : full_adder_core_if

// File: rtl/full_adder_core_bit.sv
// One-bit full-adder cell; the core chains WIDTH of these into a ripple adder.

module full_adder_bit (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic prop_s;
    logic gen_s;

    assign prop_s = a ^ b;
    assign gen_s  = a & b;

    assign s  = prop_s ^ ci;
    assign co = gen_s | (ci & prop_s);

endmodule : full_adder_bit

// File: rtl/full_adder_core.sv
// Ripple-carry adder with a zero-latency sum/carry path and a one-cycle registered
// copy carrying signed-overflow and zero flags. WIDTH=1 is a plain full adder.

module full_adder_core
    import full_adder_core_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    full_adder_core_if.slave   bus
);

    logic [WIDTH-1:0] a_s;
    logic [WIDTH-1:0] b_s;
    logic [WIDTH-1:0] sum_s;
    logic [WIDTH:0]   carry_s;
    logic             ovf_s;
    logic             zero_s;

    logic [WIDTH-1:0] sum_d;
    logic [WIDTH-1:0] sum_q;
    logic             cout_d;
    logic             cout_q;
    logic             ovf_d;
    logic             ovf_q;
    logic             zero_d;
    logic             zero_q;
    logic             valid_d;
    logic             valid_q;

    assign a_s        = bus.A_i;
    assign b_s        = bus.B_i;
    assign carry_s[0] = bus.Cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        full_adder_bit u_cell (
            .a  (a_s[i]),
            .b  (b_s[i]),
            .ci (carry_s[i]),
            .s  (sum_s[i]),
            .co (carry_s[i+1])
        );
    end : g_cell

    // Signed overflow: carry into the sign bit differs from carry out of it.
    // For WIDTH=1 the carry into the sign bit is Cin itself.
    assign ovf_s  = carry_s[WIDTH] ^ carry_s[WIDTH-1];
    assign zero_s = (sum_s == {WIDTH{1'b0}});

    assign bus.Sum  = sum_s;
    assign bus.Cout = carry_s[WIDTH];

    // Next-state for the result stage: load on in_valid, otherwise hold.
    always_comb begin
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        valid_d = bus.in_valid;
        if (bus.in_valid) begin
            sum_d  = sum_s;
            cout_d = carry_s[WIDTH];
            ovf_d  = ovf_s;
            zero_d = zero_s;
        end else begin
            sum_d  = sum_q;
            cout_d = cout_q;
            ovf_d  = ovf_q;
            zero_d = zero_q;
        end
    end

    // Result stage registers; reset discards any in-flight result immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sum_q   <= {WIDTH{1'b0}};
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
            valid_q <= valid_d;
        end
    end

    assign bus.Sum_q     = sum_q;
    assign bus.Cout_q    = cout_q;
    assign bus.Ovf_q     = ovf_q;
    assign bus.Zero_q    = zero_q;
    assign bus.out_valid = valid_q;

endmodule : full_adder_core

// File: tb/tb_full_adder_core.sv
// Self-checking bench for full_adder_core at WIDTH=32 and WIDTH=1, using a
// plain-arithmetic reference model for sums, carries and flags.

module tb_full_adder_core;
    import full_adder_core_pkg::*;

    typedef struct packed {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } res_t;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    full_adder_core_if #(.WIDTH(32)) bus32 ();
    full_adder_core_if #(.WIDTH(1))  bus1 ();

    full_adder_core #(.WIDTH(32)) u_dut32 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus32.slave)
    );

    full_adder_core #(.WIDTH(1)) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: integer add, overflow when like-signed operands give an unlike-signed sum.
    function automatic res_t model32(input logic [31:0] a, input logic [31:0] b, input logic cin);
        res_t        r;
        logic [32:0] t;
        t      = {1'b0, a} + {1'b0, b} + {32'd0, cin};
        r.sum  = t[31:0];
        r.cout = t[32];
        r.ovf  = (a[31] == b[31]) && (t[31] != a[31]);
        r.zero = (t[31:0] == 32'd0);
        return r;
    endfunction

    task automatic test_reset();
        reset          = 1'b0;
        bus32.in_valid = 1'b1;
        bus32.A_i      = 32'h0000_0005;
        bus32.B_i      = 32'h0000_0007;
        bus32.Cin      = 1'b0;
        bus1.in_valid  = 1'b1;
        bus1.A_i       = 1'b1;
        bus1.B_i       = 1'b0;
        bus1.Cin       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({bus32.Sum_q, bus32.Cout_q, bus32.Ovf_q, bus32.Zero_q, bus32.out_valid} !== 36'd0) begin
            n_fail++;
            $display("FAIL reset32: Sum_q=%h Cout_q=%b Ovf_q=%b Zero_q=%b out_valid=%b, required all 0",
                     bus32.Sum_q, bus32.Cout_q, bus32.Ovf_q, bus32.Zero_q, bus32.out_valid);
        end
        n_checks++;
        if ({bus1.Sum_q, bus1.Cout_q, bus1.Ovf_q, bus1.Zero_q, bus1.out_valid} !== 5'd0) begin
            n_fail++;
            $display("FAIL reset1: regs=%b, required 00000",
                     {bus1.Sum_q, bus1.Cout_q, bus1.Ovf_q, bus1.Zero_q, bus1.out_valid});
        end
        n_checks++;
        if (bus32.Sum !== 32'd12) begin
            n_fail++;
            $display("FAIL reset_comb: Sum=%h required 0000000c", bus32.Sum);
        end
        @(negedge clk);
        bus32.in_valid = 1'b0;
        bus1.in_valid  = 1'b0;
        reset          = 1'b1;
    endtask

    task automatic test_width1();
        logic [1:0] t;
        logic       a;
        logic       b;
        logic       c;
        logic       e_ovf;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            a = i[2];
            b = i[1];
            c = i[0];
            bus1.A_i      = a;
            bus1.B_i      = b;
            bus1.Cin      = c;
            bus1.in_valid = 1'b1;
            t     = {1'b0, a} + {1'b0, b} + {1'b0, c};
            e_ovf = (a == b) && (t[0] != a);
            #1;
            n_checks++;
            if ({bus1.Cout, bus1.Sum} !== t) begin
                n_fail++;
                $display("FAIL w1_comb %0d%0d%0d: Cout,Sum=%b required %b", a, b, c, {bus1.Cout, bus1.Sum}, t);
            end
            @(posedge clk);
            #1;
            n_checks++;
            if ({bus1.Sum_q, bus1.Cout_q, bus1.Ovf_q, bus1.Zero_q, bus1.out_valid} !==
                {t[0], t[1], e_ovf, ~t[0], 1'b1}) begin
                n_fail++;
                $display("FAIL w1_reg %0d%0d%0d: regs=%b required %b", a, b, c,
                         {bus1.Sum_q, bus1.Cout_q, bus1.Ovf_q, bus1.Zero_q, bus1.out_valid},
                         {t[0], t[1], e_ovf, ~t[0], 1'b1});
            end
        end
        @(negedge clk);
        bus1.in_valid = 1'b0;
    endtask

    task automatic test_directed();
        logic [31:0] ta [7] = '{RESET_VECTOR, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000,
                                32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0010};
        logic [31:0] tb [7] = '{32'h0000_0004, 32'h0000_0001, 32'h0000_0001, 32'hFFFF_FFFF,
                                32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFF8};
        logic        tc [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [31:0] es [7] = '{32'h8000_0004, 32'h0000_0000, 32'h8000_0000, 32'h7FFF_FFFF,
                                32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0008};
        logic        ec [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic        eo [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic        ez;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            bus32.A_i      = ta[i];
            bus32.B_i      = tb[i];
            bus32.Cin      = tc[i];
            bus32.in_valid = 1'b1;
            ez             = (es[i] == 32'd0);
            #1;
            n_checks++;
            if (bus32.Sum !== es[i] || bus32.Cout !== ec[i]) begin
                n_fail++;
                $display("FAIL dir_comb[%0d]: Sum=%h Cout=%b required Sum=%h Cout=%b",
                         i, bus32.Sum, bus32.Cout, es[i], ec[i]);
            end
            @(posedge clk);
            #1;
            n_checks++;
            if (bus32.Sum_q !== es[i] || bus32.Cout_q !== ec[i] || bus32.Ovf_q !== eo[i] ||
                bus32.Zero_q !== ez || bus32.out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL dir_reg[%0d]: Sum_q=%h C=%b O=%b Z=%b V=%b required %h %b %b %b 1",
                         i, bus32.Sum_q, bus32.Cout_q, bus32.Ovf_q, bus32.Zero_q, bus32.out_valid,
                         es[i], ec[i], eo[i], ez);
            end
        end
    endtask

    task automatic test_hold();
        res_t m;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus32.A_i      = $urandom;
            bus32.B_i      = $urandom;
            bus32.Cin      = 1'($urandom_range(0, 1));
            bus32.in_valid = 1'b0;
            m = model32(bus32.A_i, bus32.B_i, bus32.Cin);
            #1;
            n_checks++;
            if (bus32.Sum !== m.sum || bus32.Cout !== m.cout) begin
                n_fail++;
                $display("FAIL hold_comb[%0d]: Sum=%h Cout=%b required %h %b", i, bus32.Sum, bus32.Cout, m.sum, m.cout);
            end
            @(posedge clk);
            #1;
            n_checks++;
            if (bus32.Sum_q !== 32'h8000_0008 || bus32.Cout_q !== 1'b1 || bus32.Ovf_q !== 1'b0 ||
                bus32.Zero_q !== 1'b0 || bus32.out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_reg[%0d]: Sum_q=%h C=%b O=%b Z=%b V=%b required 80000008 1 0 0 0",
                         i, bus32.Sum_q, bus32.Cout_q, bus32.Ovf_q, bus32.Zero_q, bus32.out_valid);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] corner [4] = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000};
        res_t        m;
        res_t        held;
        logic        v;
        held = '0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            bus32.A_i      = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
            bus32.B_i      = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
            bus32.Cin      = 1'($urandom_range(0, 1));
            v              = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            bus32.in_valid = v;
            m = model32(bus32.A_i, bus32.B_i, bus32.Cin);
            if (v) held = m;
            #1;
            n_checks++;
            if (bus32.Sum !== m.sum || bus32.Cout !== m.cout) begin
                n_fail++;
                $display("FAIL rnd_comb[%0d]: %h+%h+%b Sum=%h Cout=%b required %h %b",
                         i, bus32.A_i, bus32.B_i, bus32.Cin, bus32.Sum, bus32.Cout, m.sum, m.cout);
            end
            @(posedge clk);
            #1;
            n_checks++;
            if (bus32.Sum_q !== held.sum || bus32.Cout_q !== held.cout || bus32.Ovf_q !== held.ovf ||
                bus32.Zero_q !== held.zero || bus32.out_valid !== v) begin
                n_fail++;
                $display("FAIL rnd_reg[%0d]: Sum_q=%h C=%b O=%b Z=%b V=%b required %h %b %b %b %b",
                         i, bus32.Sum_q, bus32.Cout_q, bus32.Ovf_q, bus32.Zero_q, bus32.out_valid,
                         held.sum, held.cout, held.ovf, held.zero, v);
            end
        end
    endtask

    task automatic test_async_reset();
        res_t m;
        @(negedge clk);
        bus32.A_i      = 32'h1234_5678;
        bus32.B_i      = 32'h1111_1111;
        bus32.Cin      = 1'b1;
        bus32.in_valid = 1'b1;
        m = model32(bus32.A_i, bus32.B_i, bus32.Cin);
        @(posedge clk);
        #1;
        n_checks++;
        if (bus32.out_valid !== 1'b1 || bus32.Sum_q !== m.sum) begin
            n_fail++;
            $display("FAIL arst_pre: out_valid=%b Sum_q=%h required 1 %h", bus32.out_valid, bus32.Sum_q, m.sum);
        end
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if ({bus32.Sum_q, bus32.Cout_q, bus32.Ovf_q, bus32.Zero_q, bus32.out_valid} !== 36'd0) begin
            n_fail++;
            $display("FAIL arst_clear: Sum_q=%h C=%b O=%b Z=%b V=%b required all 0",
                     bus32.Sum_q, bus32.Cout_q, bus32.Ovf_q, bus32.Zero_q, bus32.out_valid);
        end
        n_checks++;
        if (bus32.Sum !== m.sum || bus32.Cout !== m.cout) begin
            n_fail++;
            $display("FAIL arst_comb: Sum=%h Cout=%b required %h %b", bus32.Sum, bus32.Cout, m.sum, m.cout);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (bus32.out_valid !== 1'b0 || bus32.Sum_q !== 32'd0) begin
            n_fail++;
            $display("FAIL arst_held: out_valid=%b Sum_q=%h required 0 00000000", bus32.out_valid, bus32.Sum_q);
        end
        @(negedge clk);
        reset          = 1'b1;
        bus32.A_i      = 32'h0000_0100;
        bus32.B_i      = 32'hFFFF_FF00;
        bus32.Cin      = 1'b0;
        bus32.in_valid = 1'b1;
        m = model32(bus32.A_i, bus32.B_i, bus32.Cin);
        #1;
        n_checks++;
        if (bus32.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL arst_release: out_valid=%b required 0", bus32.out_valid);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (bus32.out_valid !== 1'b1 || bus32.Sum_q !== m.sum || bus32.Cout_q !== m.cout ||
            bus32.Zero_q !== m.zero || bus32.Ovf_q !== m.ovf) begin
            n_fail++;
            $display("FAIL arst_first: V=%b Sum_q=%h C=%b Z=%b O=%b required 1 %h %b %b %b",
                     bus32.out_valid, bus32.Sum_q, bus32.Cout_q, bus32.Zero_q, bus32.Ovf_q,
                     m.sum, m.cout, m.zero, m.ovf);
        end
        @(negedge clk);
        bus32.in_valid = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_width1();
        test_directed();
        test_hold();
        test_random();
        test_async_reset();
        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_full_adder_core
